int_to_bfloat_converter: RTL and testbench

//  Converts a signed two's-complement integer into a bfloat16 operand (1|8|7, bias 127).

---
 rtl/int_to_bfloat_if.sv | 36 +++
 rtl/int_to_bfloat_converter.sv | 134 +++++++++++++
 tb/tb_int_to_bfloat_converter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/int_to_bfloat_if.sv
// rtl/int_to_bfloat_if.sv - handshake bundle between an integer producer, the converter and a bfloat16 consumer
//
// Signals:
//   in_valid / in_ready / in_data    integer input handshake (IN_WIDTH-bit signed data)
//   out_valid / out_ready / out_data bfloat16 output handshake {sign, exp[7:0], mant[6:0]}
// Modports:
//   slave  - the converter: receives in_*, sources out_*
//   master - the environment: sources in_*, receives out_*
interface int_to_bfloat_if #(
    parameter int IN_WIDTH = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/int_to_bfloat_converter.sv
// rtl/int_to_bfloat_converter.sv - iterative signed integer to bfloat16 converter, round-to-nearest-even
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - int_to_bfloat_if.slave: in_valid/in_ready/in_data accept one integer,
//            out_valid/out_ready/out_data deliver the bfloat16 result
// One conversion in flight. The magnitude is shifted left one bit per cycle until
// its MSB is set, so latency after acceptance is leading_zeros + 2 cycles (0 for zero).
module int_to_bfloat_converter #(
    parameter int IN_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    int_to_bfloat_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [IN_WIDTH-1:0] mag, mag_next;
    logic [5:0]          cnt, cnt_next;
    logic                sign, sign_next;
    logic [15:0]         out_data_q, out_data_next;
    logic                out_valid_q, out_valid_next;

    // Absolute value as an unsigned IN_WIDTH-bit number; the most negative input
    // wraps to exactly 1 << (IN_WIDTH-1), which is the correct magnitude.
    logic [IN_WIDTH-1:0] in_abs;
    assign in_abs = bus.in_data[IN_WIDTH-1] ? (~bus.in_data + IN_WIDTH'(1)) : bus.in_data;

    // Rounding datapath, valid once mag is normalised (MSB is the hidden bit).
    logic [6:0]  mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [7:0]  mant_sum;
    logic [7:0]  exp_base;
    logic [7:0]  exp_fin;
    logic [15:0] result;

    assign mant  = mag[IN_WIDTH-2 -: 7];
    assign guard = mag[IN_WIDTH-9];

    generate
        if (IN_WIDTH > 9) begin : g_sticky
            assign sticky = |mag[IN_WIDTH-10:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    assign round_up = guard & (sticky | mant[0]);
    // Bit 7 of the sum is the carry out of an all-ones mantissa; it bumps the exponent
    // and leaves the mantissa at zero.
    assign mant_sum = {1'b0, mant} + {7'd0, round_up};
    assign exp_base = 8'(127 + IN_WIDTH - 1) - {2'b00, cnt};
    assign exp_fin  = exp_base + {7'd0, mant_sum[7]};
    assign result   = {sign, exp_fin, mant_sum[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mag         <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            mag         <= mag_next;
            cnt         <= cnt_next;
            sign        <= sign_next;
            out_data_q  <= out_data_next;
            out_valid_q <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state;
        mag_next       = mag;
        cnt_next       = cnt;
        sign_next      = sign;
        out_data_next  = out_data_q;
        out_valid_next = out_valid_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_next = '0;
                    mag_next = in_abs;
                    if (bus.in_data == '0) begin
                        // Zero bypasses normalisation; sign is forced positive.
                        sign_next      = 1'b0;
                        out_data_next  = 16'h0000;
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        sign_next  = bus.in_data[IN_WIDTH-1];
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[IN_WIDTH-1]) begin
                    state_next = ROUND;
                end else begin
                    mag_next = mag << 1;
                    cnt_next = cnt + 6'd1;
                end
            end
            ROUND: begin
                out_data_next  = result;
                out_valid_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_int_to_bfloat_converter.sv
// tb/tb_int_to_bfloat_converter.sv - directed vector bench for int_to_bfloat_converter
module tb_int_to_bfloat_converter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int_to_bfloat_if #(.IN_WIDTH(16)) bus ();

    int_to_bfloat_converter #(.IN_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one input, return the result and the number of edges from acceptance to out_valid.
    task automatic convert(input logic [15:0] d, output logic [15:0] res, output int lat);
        int k;
        @(negedge clk);
        chk("in_ready_before", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hA5A5;
        chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        res = bus.out_data;
        lat = k;
    endtask

    task automatic take_output();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_xfer", {31'd0, bus.out_valid}, 32'd0);
        chk("in_ready_after_xfer", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        int          lat;
        int          seen;

        checks = 0;
        errors = 0;

        vecs[0]  = '{16'h0001, 16'h3F80, 17};
        vecs[1]  = '{16'hFFFF, 16'hBF80, 17};
        vecs[2]  = '{16'h7FFF, 16'h4700, 3};
        vecs[3]  = '{16'h8000, 16'hC700, 2};
        vecs[4]  = '{16'h0101, 16'h4380, 9};
        vecs[5]  = '{16'h0103, 16'h4382, 9};
        vecs[6]  = '{16'h0000, 16'h0000, 0};
        vecs[7]  = '{16'h0002, 16'h4000, 16};
        vecs[8]  = '{16'h00FF, 16'h437F, 10};
        vecs[9]  = '{16'h01FF, 16'h4400, 9};
        vecs[10] = '{16'hFFFD, 16'hC040, 16};
        vecs[11] = '{16'h0064, 16'h42C8, 11};
        vecs[12] = '{16'hFF9C, 16'hC2C8, 11};

        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            convert(vecs[i].din, res, lat);
            chk($sformatf("data_%0d_%h", i, vecs[i].din), {16'd0, res}, {16'd0, vecs[i].dout});
            chk($sformatf("latency_%0d_%h", i, vecs[i].din), lat, vecs[i].lat);
            take_output();
        end

        // Back-pressure: result held, new requests ignored while DONE.
        convert(16'h0064, res, lat);
        chk("bp_data", {16'd0, res}, 32'h0000_42C8);
        held = res;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1234 + 16'(c);
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_out_data", {16'd0, bus.out_data}, {16'd0, held});
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        take_output();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("bp_single_transfer", seen, 0);
        chk("bp_idle", {31'd0, bus.in_ready}, 32'd1);

        // Reset in the middle of normalising 1.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("rst_no_stale", seen, 0);

        // Still functional after reset.
        convert(16'h0103, res, lat);
        chk("post_rst_data", {16'd0, res}, 32'h0000_4382);
        chk("post_rst_latency", lat, 9);
        take_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
